// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU stage, the result buffer, writeback and decode forwarding.
// The master side is the ALU/writeback/decode environment; the slave side is the buffer.
interface alu_result_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  flush_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] result_i;
    logic [ADDR_WIDTH-1:0] waddr_i;
    logic                  wb_valid_o;
    logic                  wb_ready_i;
    logic [DATA_WIDTH-1:0] wb_data_o;
    logic [ADDR_WIDTH-1:0] wb_addr_o;
    logic [ADDR_WIDTH-1:0] fwd_addr_i;
    logic                  fwd_hit_o;
    logic [DATA_WIDTH-1:0] fwd_data_o;
    logic [CNT_WIDTH-1:0]  stall_cnt_o;

    modport master (
        output flush_i, valid_i, result_i, waddr_i, wb_ready_i, fwd_addr_i,
        input  ready_o, wb_valid_o, wb_data_o, wb_addr_o, fwd_hit_o, fwd_data_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, valid_i, result_i, waddr_i, wb_ready_i, fwd_addr_i,
        output ready_o, wb_valid_o, wb_data_o, wb_addr_o, fwd_hit_o, fwd_data_o, stall_cnt_o
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Two-entry FIFO between the ALU and writeback, with youngest-entry operand forwarding
// and a saturating count of writeback stall cycles.
module alu_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst,
    alu_result_buffer_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] ent_data [2];
    logic [ADDR_WIDTH-1:0] ent_addr [2];
    logic                  hd, hd_nxt;
    logic                  wr_en, wr_slot, tail_slot;
    logic                  push, pop;
    logic                  tail_hit, head_hit;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    // ready depends only on registered state, so the ALU never sees a path from wb_ready_i
    assign bus.ready_o    = (state != FULL);
    assign bus.wb_valid_o = (state != EMPTY);
    assign push           = bus.valid_i & bus.ready_o;
    assign pop            = bus.wb_valid_o & bus.wb_ready_i;

    always_comb begin
        state_nxt = state;
        hd_nxt    = hd;
        // writes to x0 complete the handshake but are dropped
        wr_en     = push & (bus.waddr_i != '0) & ~bus.flush_i;
        wr_slot   = hd ^ (state != EMPTY);
        if (bus.flush_i) begin
            state_nxt = EMPTY;
            hd_nxt    = 1'b0;
        end else begin
            case (state)
                EMPTY: if (wr_en) state_nxt = ONE;
                ONE: begin
                    if (pop) hd_nxt = ~hd;
                    if (wr_en && !pop)      state_nxt = FULL;
                    else if (pop && !wr_en) state_nxt = EMPTY;
                end
                FULL: if (pop) begin
                    state_nxt = ONE;
                    hd_nxt    = ~hd;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            hd          <= 1'b0;
            ent_data[0] <= '0;
            ent_data[1] <= '0;
            ent_addr[0] <= '0;
            ent_addr[1] <= '0;
        end else begin
            state <= state_nxt;
            hd    <= hd_nxt;
            if (wr_en) begin
                ent_data[wr_slot] <= bus.result_i;
                ent_addr[wr_slot] <= bus.waddr_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (bus.wb_valid_o && !bus.wb_ready_i && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.wb_data_o   = bus.wb_valid_o ? ent_data[hd] : '0;
    assign bus.wb_addr_o   = bus.wb_valid_o ? ent_addr[hd] : '0;

    // tail is the youngest entry; when only one entry is held it is also the head
    assign tail_slot = hd ^ (state == FULL);
    assign tail_hit  = (state != EMPTY) && (bus.fwd_addr_i != '0) &&
                       (ent_addr[tail_slot] == bus.fwd_addr_i);
    assign head_hit  = (state == FULL) && (bus.fwd_addr_i != '0) &&
                       (ent_addr[hd] == bus.fwd_addr_i);

    assign bus.fwd_hit_o  = tail_hit | head_hit;
    assign bus.fwd_data_o = tail_hit ? ent_data[tail_slot] :
                            head_hit ? ent_data[hd] : '0;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: a queue of expected writebacks is filled as
// results are pushed and drained by a monitor on every writeback handshake.
module tb_alu_result_buffer;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_result_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    alu_result_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t          sb[$];
    exp_t          e;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] stall_model = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wb_valid_o && bus.wb_ready_i) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wb_unexpected: got addr %0d data %0h expected no entry",
                             bus.wb_addr_o, bus.wb_data_o);
                end else begin
                    e = sb.pop_front();
                    check("wb_addr", 64'(bus.wb_addr_o), 64'(e.a));
                    check("wb_data", 64'(bus.wb_data_o), 64'(e.d));
                end
            end
            if (bus.wb_valid_o && !bus.wb_ready_i && stall_model != '1)
                stall_model = stall_model + 1'b1;
        end
    end

    task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a);
        exp_t x;
        bus.valid_i  = 1'b1;
        bus.result_i = d;
        bus.waddr_i  = a;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        x.a = a;
        x.d = d;
        if (a != '0) sb.push_back(x);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wb_valid"}, 64'(bus.wb_valid_o), 64'(0));
        check({tag, "_wb_data"}, 64'(bus.wb_data_o), 64'(0));
        check({tag, "_wb_addr"}, 64'(bus.wb_addr_o), 64'(0));
        check({tag, "_ready"}, 64'(bus.ready_o), 64'(1));
        check({tag, "_fwd_hit"}, 64'(bus.fwd_hit_o), 64'(0));
        check({tag, "_fwd_data"}, 64'(bus.fwd_data_o), 64'(0));
        check({tag, "_stall_cnt"}, 64'(bus.stall_cnt_o), 64'(0));
    endtask

    initial begin
        bus.flush_i    = 1'b0;
        bus.valid_i    = 1'b0;
        bus.result_i   = '0;
        bus.waddr_i    = '0;
        bus.wb_ready_i = 1'b0;
        bus.fwd_addr_i = '0;
        #3;
        check_reset_vals("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // SRA 4>>>1 into x5, one-cycle latency, then empty again
        bus.wb_ready_i = 1'b1;
        push(32'h2, 5'd5);
        check("t1_wb_valid", 64'(bus.wb_valid_o), 64'(1));
        check("t1_wb_data", 64'(bus.wb_data_o), 64'h2);
        check("t1_wb_addr", 64'(bus.wb_addr_o), 64'd5);
        @(posedge clk); #1;
        check("t1_empty", 64'(bus.wb_valid_o), 64'(0));

        // fill under backpressure, third push refused, then drain in order
        bus.wb_ready_i = 1'b0;
        push(32'h2, 5'd6);
        push(32'h8000_0002, 5'd7);
        check("t2_ready_full", 64'(bus.ready_o), 64'(0));
        bus.valid_i  = 1'b1;
        bus.result_i = 32'h99;
        bus.waddr_i  = 5'd8;
        repeat (3) @(posedge clk);
        #1;
        check("t2_ready_held", 64'(bus.ready_o), 64'(0));
        check("t2_head_addr_stable", 64'(bus.wb_addr_o), 64'd6);
        check("t2_head_data_stable", 64'(bus.wb_data_o), 64'h2);
        bus.valid_i    = 1'b0;
        bus.wb_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t2_drained", 64'(bus.wb_valid_o), 64'(0));

        // forwarding picks the younger of two matching entries
        bus.wb_ready_i = 1'b0;
        push(32'h14, 5'd9);
        bus.fwd_addr_i = 5'd9;
        #1;
        check("t3_single_hit", 64'(bus.fwd_hit_o), 64'(1));
        check("t3_single_data", 64'(bus.fwd_data_o), 64'h14);
        push(32'h2, 5'd9);
        check("t3_hit", 64'(bus.fwd_hit_o), 64'(1));
        check("t3_young_data", 64'(bus.fwd_data_o), 64'h2);
        bus.fwd_addr_i = 5'd6;
        #1;
        check("t3_miss_hit", 64'(bus.fwd_hit_o), 64'(0));
        check("t3_miss_data", 64'(bus.fwd_data_o), 64'(0));
        bus.fwd_addr_i = 5'd0;
        #1;
        check("t3_x0_hit", 64'(bus.fwd_hit_o), 64'(0));
        bus.wb_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // writes to x0 are accepted and dropped
        push(32'h123, 5'd0);
        check("t4_ready", 64'(bus.ready_o), 64'(1));
        check("t4_wb_valid", 64'(bus.wb_valid_o), 64'(0));

        // flush while full, with a competing push
        bus.wb_ready_i = 1'b0;
        push(32'hA, 5'd10);
        push(32'hB, 5'd11);
        check("t5_full", 64'(bus.ready_o), 64'(0));
        bus.flush_i  = 1'b1;
        bus.valid_i  = 1'b1;
        bus.result_i = 32'h77;
        bus.waddr_i  = 5'd12;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        sb.delete();
        check("t5_wb_valid", 64'(bus.wb_valid_o), 64'(0));
        check("t5_ready", 64'(bus.ready_o), 64'(1));
        check("t5_wb_data", 64'(bus.wb_data_o), 64'(0));
        check("t5_stall_kept", 64'(bus.stall_cnt_o), 64'(stall_model));

        // long stall saturates the counter, then async reset mid-cycle
        push(32'h55, 5'd13);
        repeat (70000) @(posedge clk);
        #1;
        check("t6_stall_sat", 64'(bus.stall_cnt_o), 64'hFFFF);
        check("t6_stall_model", 64'(bus.stall_cnt_o), 64'(stall_model));
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t6_async");
        sb.delete();
        stall_model = '0;
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_after_reset", 64'(bus.wb_valid_o), 64'(0));

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
